// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART pin bridge.
package uart_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam int ERR_FRAMING  = 0;
  localparam int ERR_PARITY   = 1;
  localparam int ERR_OVERRUN  = 2;
  localparam int ERR_OVERFLOW = 3;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered count; a push on full is rejected even
// when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     wen,
  input  logic                     ren,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = wen && !full;
  assign do_pop  = ren && !empty;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_pin_bridge_param.sv
// Pin-driven UART bridge: TX/RX FSMs with FIFOs, selectable divisor,
// optional even parity, RTS/CTS and sticky per-cause error flags.
module uart_pin_bridge_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int RATE0      = 5207,
  parameter int RATE1      = 2603,
  parameter int RATE2      = 1301,
  parameter int RATE3      = 433
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic [1:0]           op,
  input  logic [1:0]           rate_sel,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 tx_full,
  output logic                 rx_empty,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 cts,
  output logic                 rts,
  output logic [3:0]           err_flags,
  output logic                 err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] LAST_BIT = 16'(DATA_BITS - 1);

  op_t op_c;
  logic wr_req, rd_req, clr;
  assign op_c   = op_t'(op);
  assign wr_req = (op_c == OP_WRITE);
  assign rd_req = (op_c == OP_READ);
  assign clr    = (op_c == OP_CLEAR);

  logic [DATA_BITS-1:0] tx_head, rx_head;
  logic                 tx_full_w, tx_empty_w, rx_full_w, rx_empty_w;
  logic [CW-1:0]        tx_count, rx_count;
  logic                 tx_pop, rx_push;

  tx_state_t            tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d, tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_par_q, tx_par_d, tx_q, tx_d;

  rx_state_t            rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic                 rx_pbad_q, rx_pbad_d;
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  logic                 rx_good;

  logic [15:0]          div_q, div_d, div_m1, rate_lut;
  logic [3:0]           err_q, err_d, err_set;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .nReset(nReset), .wen(wr_req), .ren(tx_pop), .clear(clr),
    .wdata(tx_data), .rdata(tx_head), .full(tx_full_w), .empty(tx_empty_w),
    .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .nReset(nReset), .wen(rx_push), .ren(rd_req), .clear(clr),
    .wdata(rx_shreg_q), .rdata(rx_head), .full(rx_full_w), .empty(rx_empty_w),
    .count(rx_count)
  );

  logic unused_tx_count;
  assign unused_tx_count = ^tx_count;

  always_comb begin
    case (rate_sel)
      2'd0:    rate_lut = 16'(RATE0);
      2'd1:    rate_lut = 16'(RATE1);
      2'd2:    rate_lut = 16'(RATE2);
      default: rate_lut = 16'(RATE3);
    endcase
  end

  // Divisor only moves while neither FSM is (or is about to be) mid-frame.
  assign div_d  = (tx_state_d == TX_IDLE && rx_state_d == RX_IDLE) ? rate_lut : div_q;
  assign div_m1 = div_q - 16'd1;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty_w && cts && !clr) begin
          tx_pop     = 1'b1;
          tx_shreg_d = tx_head;
          tx_par_d   = ^tx_head;
          tx_cnt_d   = div_m1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = div_m1;
          tx_bit_d   = 16'd0;
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_m1;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 16'd1;
            tx_shreg_d = tx_shreg_q >> 1;
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_PARITY: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = div_m1;
          tx_state_d = TX_STOP;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_STOP: begin
        if (tx_cnt_q == 16'd0) tx_state_d = TX_IDLE;
        else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shreg_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_pbad_d  = rx_pbad_q;
    rx_good    = 1'b0;
    err_set    = 4'b0000;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_cnt_d   = (div_q >> 1) - 16'd1;
          rx_pbad_d  = 1'b0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) rx_state_d = RX_IDLE;
          else begin
            rx_cnt_d   = div_m1;
            rx_bit_d   = 16'd0;
            rx_state_d = RX_DATA;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_cnt_d   = div_m1;
          rx_shreg_d = {rx_s2_q, rx_shreg_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          else rx_bit_d = rx_bit_q + 16'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_PARITY: begin
        if (rx_cnt_q == 16'd0) begin
          rx_cnt_d   = div_m1;
          rx_pbad_d  = rx_s2_q ^ (^rx_shreg_q);
          err_set[ERR_PARITY] = rx_pbad_d;
          rx_state_d = RX_STOP;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = RX_IDLE;
          if (!rx_s2_q) err_set[ERR_FRAMING] = 1'b1;
          else if (!rx_pbad_q) begin
            if (rx_full_w) err_set[ERR_OVERRUN] = 1'b1;
            else rx_good = 1'b1;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    err_set[ERR_OVERFLOW] = wr_req && tx_full_w;
  end

  assign rx_push = rx_good && !clr;
  assign err_d   = clr ? 4'b0000 : (err_q | err_set);

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (rd_req && !rx_empty_w) begin
      rx_data_d  = rx_head;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_pbad_q  <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      div_q      <= 16'(RATE0);
      err_q      <= 4'b0000;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
      rx_pbad_q  <= rx_pbad_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      div_q      <= div_d;
      err_q      <= err_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx        = tx_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_full   = tx_full_w;
  assign rx_empty  = rx_empty_w;
  assign rts       = (rx_count != CW'(FIFO_DEPTH));
  assign err_flags = err_q;
  assign err       = |err_q;

endmodule

// File: tb/tb_uart_pin_bridge_param.sv
// Randomised bench for uart_pin_bridge_param: queue-based reference model of
// FIFO contents and error causes, serial frames encoded/decoded from bit rules.
module tb_uart_pin_bridge_param;

  localparam int BL0 = 16;
  localparam int BL1 = 10;

  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  logic [1:0] op0, rs0, op1, rs1;
  logic [7:0] txd0, rxd0, txd1, rxd1;
  logic       rxv0, txf0, rxe0, rx0, tx0, cts0, rts0, err0;
  logic       rxv1, txf1, rxe1, rx1, tx1, cts1, rts1, err1;
  logic [3:0] ef0, ef1;

  uart_pin_bridge_param #(.DATA_BITS(8), .FIFO_DEPTH(8), .PARITY_EN(0),
    .RATE0(BL0), .RATE1(BL1), .RATE2(6), .RATE3(4)) u_dut0 (
    .clk(clk), .nReset(nReset), .op(op0), .rate_sel(rs0), .tx_data(txd0),
    .rx_data(rxd0), .rx_valid(rxv0), .tx_full(txf0), .rx_empty(rxe0),
    .rx(rx0), .tx(tx0), .cts(cts0), .rts(rts0), .err_flags(ef0), .err(err0)
  );

  uart_pin_bridge_param #(.DATA_BITS(8), .FIFO_DEPTH(8), .PARITY_EN(1),
    .RATE0(BL0), .RATE1(BL1), .RATE2(6), .RATE3(4)) u_dut1 (
    .clk(clk), .nReset(nReset), .op(op1), .rate_sel(rs1), .tx_data(txd1),
    .rx_data(rxd1), .rx_valid(rxv1), .tx_full(txf1), .rx_empty(rxe1),
    .rx(rx1), .tx(tx1), .cts(cts1), .rts(rts1), .err_flags(ef1), .err(err1)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q_tx[$];
  logic [7:0] q_rx[$];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
  endtask

  // Serial frame onto rx of DUT sel: start, LSB-first data, optional parity, stop.
  task automatic send_frame(input int sel, input logic [7:0] b, input bit use_par,
                            input logic par_bit, input logic stop_bit, input int bl);
    set_line(sel, 1'b0);
    repeat (bl) tick();
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      repeat (bl) tick();
    end
    if (use_par) begin
      set_line(sel, par_bit);
      repeat (bl) tick();
    end
    set_line(sel, stop_bit);
    repeat (bl) tick();
    set_line(sel, 1'b1);
  endtask

  // Decode one frame from DUT0 tx, requiring each bit to hold exactly bl cycles.
  task automatic get_frame(input int bl, output logic [7:0] b);
    int w = 0;
    int viol = 0;
    logic v;
    b = '0;
    while (tx0 !== 1'b0 && w < 3000) begin
      tick();
      w++;
    end
    chk_val("tx_start_seen", 32'(w < 3000), 1);
    for (int k = 0; k < 10; k++) begin
      v = tx0;
      for (int c = 0; c < bl; c++) begin
        if (tx0 !== v) viol++;
        tick();
      end
      if (k == 0 && v !== 1'b0) viol++;
      else if (k == 9 && v !== 1'b1) viol++;
      else if (k > 0 && k < 9) b[k-1] = v;
    end
    chk_val("tx_bit_timing", 32'(viol), 0);
  endtask

  task automatic op_pulse(input int sel, input logic [1:0] o, input logic [7:0] d);
    if (sel == 0) begin op0 = o; txd0 = d; end
    else begin op1 = o; txd1 = d; end
    tick();
    if (sel == 0) op0 = 2'd0;
    else op1 = 2'd0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b, b1, b2, v;
    logic       p;
    int         lows;
    bit         exp_ovf;
    bit         exp_ovr;

    nReset = 1'b0;
    op0 = 2'd0; rs0 = 2'd0; txd0 = '0; rx0 = 1'b1; cts0 = 1'b0;
    op1 = 2'd0; rs1 = 2'd0; txd1 = '0; rx1 = 1'b1; cts1 = 1'b0;
    repeat (3) tick();
    nReset = 1'b1;
    tick();

    chk_val("rst_tx", 32'(tx0), 1);
    chk_val("rst_rx_data", 32'(rxd0), 0);
    chk_val("rst_rx_valid", 32'(rxv0), 0);
    chk_val("rst_err_flags", 32'(ef0), 0);
    chk_val("rst_rts", 32'(rts0), 1);
    chk_val("rst_tx_full", 32'(txf0), 0);
    chk_val("rst_rx_empty", 32'(rxe0), 1);
    chk_val("rst_tx_p", 32'(tx1), 1);

    // Loopback timing: push at N, tx low from N+2, 160-cycle frame.
    cts0 = 1'b1;
    op_pulse(0, 2'd1, 8'hA5);
    chk_val("lb_tx_n1", 32'(tx0), 1);
    tick();
    chk_val("lb_tx_n2_low", 32'(tx0), 0);
    get_frame(BL0, b);
    chk_val("lb_data", 32'(b), 'hA5);
    chk_val("lb_idle_after", 32'(tx0), 1);

    // TX FIFO fill with cts low, overflow on the ninth WRITE.
    cts0 = 1'b0;
    q_tx.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < 9; i++) begin
      v = 8'($urandom);
      if (q_tx.size() < 8) q_tx.push_back(v);
      else exp_ovf = 1'b1;
      op_pulse(0, 2'd1, v);
      if (i == 6) chk_val("txf_after7", 32'(txf0), 0);
      if (i == 7) chk_val("txf_after8", 32'(txf0), 1);
    end
    chk_val("ovf_flag", 32'(ef0[3]), 32'(exp_ovf));
    chk_val("ovf_err", 32'(err0), 1);
    lows = 0;
    repeat (40) begin
      if (tx0 !== 1'b1) lows++;
      tick();
    end
    chk_val("cts_hold_tx", 32'(lows), 0);
    cts0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      get_frame(BL0, b);
      chk_val("tx_fifo_order", 32'(b), 32'(q_tx.pop_front()));
    end
    lows = 0;
    repeat (60) begin
      if (tx0 !== 1'b1) lows++;
      tick();
    end
    chk_val("tx_no_ninth", 32'(lows), 0);
    op_pulse(0, 2'd3, 8'h00);
    chk_val("clear_flags", 32'(ef0), 0);

    // RX single known frame.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, BL0);
    repeat (4) tick();
    chk_val("rx_nonempty", 32'(rxe0), 0);
    op_pulse(0, 2'd2, 8'h00);
    chk_val("rx_valid_pulse", 32'(rxv0), 1);
    chk_val("rx_data_3c", 32'(rxd0), 'h3C);
    chk_val("rx_err_none", 32'(err0), 0);
    tick();
    chk_val("rx_valid_drop", 32'(rxv0), 0);
    chk_val("rx_empty_again", 32'(rxe0), 1);
    op_pulse(0, 2'd2, 8'h00);
    chk_val("rd_empty_valid", 32'(rxv0), 0);
    chk_val("rd_empty_hold", 32'(rxd0), 'h3C);
    chk_val("rd_empty_noerr", 32'(ef0), 0);

    // RX random fill, RTS drop and overrun on the ninth frame.
    q_rx.delete();
    exp_ovr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      v = 8'($urandom);
      send_frame(0, v, 1'b0, 1'b0, 1'b1, BL0);
      if (q_rx.size() < 8) q_rx.push_back(v);
      else exp_ovr = 1'b1;
      if (i == 6) chk_val("rts_after7", 32'(rts0), 1);
      if (i == 7) chk_val("rts_after8", 32'(rts0), 0);
    end
    repeat (4) tick();
    chk_val("ovr_flags", 32'(ef0), 32'({1'b0, exp_ovr, 2'b00}));
    for (int i = 0; i < 8; i++) begin
      op_pulse(0, 2'd2, 8'h00);
      chk_val("rx_read_valid", 32'(rxv0), 1);
      chk_val("rx_fifo_order", 32'(rxd0), 32'(q_rx.pop_front()));
    end
    chk_val("rx_drained", 32'(rxe0), 1);
    chk_val("rts_back", 32'(rts0), 1);
    op_pulse(0, 2'd3, 8'h00);
    chk_val("clear_ovr", 32'(ef0), 0);

    // Rate change mid-frame: current frame RATE0, next frame RATE1.
    cts0 = 1'b0;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    op_pulse(0, 2'd1, b1);
    op_pulse(0, 2'd1, b2);
    cts0 = 1'b1;
    fork
      get_frame(BL0, b);
      begin
        repeat (60) tick();
        rs0 = 2'd1;
      end
    join
    chk_val("rate_frame1", 32'(b), 32'(b1));
    get_frame(BL1, b);
    chk_val("rate_frame2", 32'(b), 32'(b2));

    // False start glitch at RATE1, then a real RATE1 frame.
    rx0 = 1'b0;
    repeat (4) tick();
    rx0 = 1'b1;
    repeat (40) tick();
    chk_val("glitch_empty", 32'(rxe0), 1);
    chk_val("glitch_noflag", 32'(ef0), 0);
    v = 8'($urandom);
    send_frame(0, v, 1'b0, 1'b0, 1'b1, BL1);
    repeat (4) tick();
    op_pulse(0, 2'd2, 8'h00);
    chk_val("rate1_rx_data", 32'(rxd0), 32'(v));
    rs0 = 2'd0;

    // Parity build: bad parity, then framing error, then CLEAR.
    send_frame(1, 8'h01, 1'b1, 1'b0, 1'b1, BL0);
    repeat (4) tick();
    chk_val("par_flags", 32'(ef1), 'b0010);
    chk_val("par_discard", 32'(rxe1), 1);
    send_frame(1, 8'h55, 1'b1, 1'b0, 1'b0, BL0);
    repeat (4) tick();
    chk_val("fram_flags", 32'(ef1), 'b0011);
    chk_val("fram_discard", 32'(rxe1), 1);
    op_pulse(1, 2'd3, 8'h00);
    chk_val("par_clear", 32'(ef1), 0);
    chk_val("par_clear_err", 32'(err1), 0);
    v = 8'($urandom);
    send_frame(1, v, 1'b1, ^v, 1'b1, BL0);
    repeat (4) tick();
    op_pulse(1, 2'd2, 8'h00);
    chk_val("par_good_data", 32'(rxd1), 32'(v));
    chk_val("par_good_noerr", 32'(ef1), 0);

    // Parity build TX: mid-bit sampling of data, parity and stop.
    v = 8'($urandom);
    cts1 = 1'b1;
    op_pulse(1, 2'd1, v);
    lows = 0;
    while (tx1 !== 1'b0 && lows < 100) begin
      tick();
      lows++;
    end
    repeat (BL0 / 2) tick();
    b = '0;
    for (int i = 0; i < 8; i++) begin
      repeat (BL0) tick();
      b[i] = tx1;
    end
    repeat (BL0) tick();
    p = tx1;
    chk_val("ptx_data", 32'(b), 32'(v));
    chk_val("ptx_parity", 32'(p), 32'(^v));
    repeat (BL0) tick();
    chk_val("ptx_stop", 32'(tx1), 1);

    // Asynchronous reset mid-frame.
    op_pulse(0, 2'd1, 8'h00);
    op_pulse(0, 2'd1, 8'h00);
    repeat (30) tick();
    chk_val("pre_rst_tx_low", 32'(tx0), 0);
    nReset = 1'b0;
    #2;
    chk_val("rst_mid_tx", 32'(tx0), 1);
    chk_val("rst_mid_rxe", 32'(rxe0), 1);
    chk_val("rst_mid_txf", 32'(txf0), 0);
    tick();
    nReset = 1'b1;
    lows = 0;
    repeat (40) begin
      if (tx0 !== 1'b1) lows++;
      tick();
    end
    chk_val("rst_fifo_flushed", 32'(lows), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
